fx_link_ctrl: RTL and testbench

FX_LINK_CTRL -- requirements
Module: fx_link_ctrl

---
 rtl/fx_ctrl_pkg.sv | 20 ++
 rtl/setting_sync.sv | 74 +++++++
 rtl/fx_link_ctrl.sv | 168 ++++++++++++++++
 tb/tb_fx_link_ctrl.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/fx_ctrl_pkg.sv
// Shared types and default constants for the fx_link_ctrl I2S link supervisor.
package fx_ctrl_pkg;

   typedef enum logic [1:0] {
      StSync,
      StRun,
      StFault,
      StRecover
   } link_state_e;

   typedef logic [3:0] setting_t;

   localparam int unsigned DefWidth          = 16;
   localparam int unsigned DefWdogCycles     = 64;
   localparam int unsigned DefRecoverCycles  = 8;
   localparam int unsigned DefDebounceFrames = 4;

   localparam setting_t SettingRst = 4'h1;

endpackage

// File: rtl/setting_sync.sv
// Two-flop synchronizer for one 4-bit switch setting, with optional frame-based debounce
// enabled by the FX_PARAM_DEBOUNCE_EN macro.
module setting_sync
   import fx_ctrl_pkg::*;
`ifdef FX_PARAM_DEBOUNCE_EN
#(
   parameter int unsigned DEBOUNCE_FRAMES = DefDebounceFrames
)
`endif
(
   input  logic     clk_i,
   input  logic     rst_ni,
`ifdef FX_PARAM_DEBOUNCE_EN
   input  logic     accept_i,
`endif
   input  setting_t raw_i,
   output setting_t cand_o
);

   setting_t meta_q, sync_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta_q <= SettingRst;
         sync_q <= SettingRst;
      end else begin
         meta_q <= raw_i;
         sync_q <= meta_q;
      end
   end

`ifdef FX_PARAM_DEBOUNCE_EN
   localparam int unsigned CntW = $clog2(DEBOUNCE_FRAMES + 1);

   logic [CntW-1:0] cnt_q, cnt_d;
   setting_t        last_q, last_d;
   setting_t        cand_q, cand_d;

   always_comb begin
      cnt_d  = cnt_q;
      last_d = last_q;
      cand_d = cand_q;
      if (accept_i) begin
         last_d = sync_q;
         if (sync_q != last_q) begin
            cnt_d = CntW'(1);
         end else if (cnt_q < CntW'(DEBOUNCE_FRAMES)) begin
            cnt_d = cnt_q + 1'b1;
         end
         if (cnt_d >= CntW'(DEBOUNCE_FRAMES)) begin
            cand_d = sync_q;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q  <= '0;
         last_q <= SettingRst;
         cand_q <= SettingRst;
      end else begin
         cnt_q  <= cnt_d;
         last_q <= last_d;
         cand_q <= cand_d;
      end
   end

   // Combinational so the frame start that completes the run can apply it at once.
   assign cand_o = cand_d;
`else
   assign cand_o = sync_q;
`endif

endmodule

// File: rtl/fx_link_ctrl.sv
// I2S link supervisor: frame-length check, ws watchdog, fault/recover sequencing and
// frame-aligned effect-parameter updates. FX_PARAM_DEBOUNCE_EN enables setting debounce.
module fx_link_ctrl
   import fx_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH           = DefWidth,
   parameter int unsigned WDOG_CYCLES     = DefWdogCycles,
   parameter int unsigned RECOVER_CYCLES  = DefRecoverCycles,
   parameter int unsigned DEBOUNCE_FRAMES = DefDebounceFrames
) (
   input  logic       sclk_i,
   input  logic       rst_n_i,
   input  logic       ws_i,
   input  logic [3:0] freqSetting_i,
   input  logic [3:0] scaleFactor_i,
   output logic [3:0] freq_o,
   output logic [3:0] scale_o,
   output logic       paramUpdate_o,
   output logic       frameStart_o,
   output logic       errorLED,
   output logic       rstI2S_n
);

   localparam int unsigned FrameLast = 2 * WIDTH - 1;
   localparam int unsigned FrameCntW = $clog2(2 * WIDTH + 1);
   localparam int unsigned WdogW     = $clog2(WDOG_CYCLES + 1);
   localparam int unsigned RecW      = $clog2(RECOVER_CYCLES + 1);

   link_state_e          state_q, state_d;
   logic                 ws_q;
   logic [FrameCntW-1:0] frame_cnt_q, frame_cnt_d;
   logic [WdogW-1:0]     wdog_q, wdog_d;
   logic [RecW-1:0]      rec_q, rec_d;
   setting_t             freq_q, freq_d, scale_q, scale_d;
   logic                 upd_q, upd_d, fs_q, fs_d, err_q, err_d, rst_i2s_q, rst_i2s_d;
   setting_t             freq_cand, scale_cand;
   logic                 ws_fall, ws_edge, wdog_hit;

   setting_sync u_freq_sync (
      .clk_i    (sclk_i),
      .rst_ni   (rst_n_i),
`ifdef FX_PARAM_DEBOUNCE_EN
      .accept_i (fs_d),
`endif
      .raw_i    (freqSetting_i),
      .cand_o   (freq_cand)
   );

   setting_sync u_scale_sync (
      .clk_i    (sclk_i),
      .rst_ni   (rst_n_i),
`ifdef FX_PARAM_DEBOUNCE_EN
      .accept_i (fs_d),
`endif
      .raw_i    (scaleFactor_i),
      .cand_o   (scale_cand)
   );

   assign ws_fall  = ws_q & ~ws_i;
   assign ws_edge  = ws_q ^ ws_i;
   assign wdog_hit = !ws_edge && (wdog_q >= WdogW'(WDOG_CYCLES - 1));

   always_comb begin
      state_d     = state_q;
      frame_cnt_d = (frame_cnt_q == '1) ? frame_cnt_q : frame_cnt_q + 1'b1;
      if (ws_edge) begin
         wdog_d = '0;
      end else if (wdog_q >= WdogW'(WDOG_CYCLES)) begin
         wdog_d = wdog_q;
      end else begin
         wdog_d = wdog_q + 1'b1;
      end
      rec_d   = rec_q;
      freq_d  = freq_q;
      scale_d = scale_q;
      upd_d   = 1'b0;
      fs_d    = 1'b0;
      err_d   = err_q;

      unique case (state_q)
         StSync: begin
            if (wdog_hit) begin
               state_d = StFault;
            end else if (ws_fall) begin
               state_d     = StRun;
               frame_cnt_d = '0;
               fs_d        = 1'b1;
            end
         end
         StRun: begin
            if (wdog_hit) begin
               state_d = StFault;
            end else if (ws_fall) begin
               // A length fault at a frame start suppresses the pulse and any update.
               if (frame_cnt_q != FrameCntW'(FrameLast)) begin
                  state_d = StFault;
               end else begin
                  frame_cnt_d = '0;
                  fs_d        = 1'b1;
                  if ((freq_cand != freq_q) || (scale_cand != scale_q)) begin
                     freq_d  = freq_cand;
                     scale_d = scale_cand;
                     upd_d   = 1'b1;
                  end
               end
            end
         end
         StFault: begin
            state_d = StRecover;
            rec_d   = rec_q + 1'b1;
         end
         StRecover: begin
            // FAULT already holds rstI2S_n low for the first of the RECOVER_CYCLES.
            if (rec_q >= RecW'(RECOVER_CYCLES - 1)) begin
               state_d = StSync;
            end else begin
               rec_d = rec_q + 1'b1;
            end
         end
         default: state_d = StSync;
      endcase

      if ((state_q == StFault) || (state_q == StRecover)) begin
         wdog_d = '0;
      end
      if (state_d == StFault) begin
         err_d = 1'b1;
         rec_d = '0;
      end
      rst_i2s_d = !((state_d == StFault) || (state_d == StRecover));
   end

   always_ff @(posedge sclk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q     <= StSync;
         ws_q        <= 1'b0;
         frame_cnt_q <= '0;
         wdog_q      <= '0;
         rec_q       <= '0;
         freq_q      <= SettingRst;
         scale_q     <= SettingRst;
         upd_q       <= 1'b0;
         fs_q        <= 1'b0;
         err_q       <= 1'b0;
         rst_i2s_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         ws_q        <= ws_i;
         frame_cnt_q <= frame_cnt_d;
         wdog_q      <= wdog_d;
         rec_q       <= rec_d;
         freq_q      <= freq_d;
         scale_q     <= scale_d;
         upd_q       <= upd_d;
         fs_q        <= fs_d;
         err_q       <= err_d;
         rst_i2s_q   <= rst_i2s_d;
      end
   end

   assign freq_o        = freq_q;
   assign scale_o       = scale_q;
   assign paramUpdate_o = upd_q;
   assign frameStart_o  = fs_q;
   assign errorLED      = err_q;
   assign rstI2S_n      = rst_i2s_q;

endmodule

// File: tb/tb_fx_link_ctrl.sv
// Directed bench for fx_link_ctrl: framing, parameter updates, watchdog, short frame, reset.
module tb_fx_link_ctrl;

   logic       sclk = 1'b0;
   logic       rst_n;
   logic       ws;
   logic [3:0] freq_r, scale_r;
   logic [3:0] freq_o, scale_o;
   logic       pu_o, fs_o, err_led, rst_i2s_n;

   int total = 0;
   int bad   = 0;
   int fs_cnt, pu_cnt, low_cnt;
   int first_low;

`ifdef FX_PARAM_DEBOUNCE_EN
   localparam int Target = 4;
`else
   localparam int Target = 1;
`endif

   fx_link_ctrl dut (
      .sclk_i        (sclk),
      .rst_n_i       (rst_n),
      .ws_i          (ws),
      .freqSetting_i (freq_r),
      .scaleFactor_i (scale_r),
      .freq_o        (freq_o),
      .scale_o       (scale_o),
      .paramUpdate_o (pu_o),
      .frameStart_o  (fs_o),
      .errorLED      (err_led),
      .rstI2S_n      (rst_i2s_n)
   );

   always #5 sclk = ~sclk;

   task automatic check_eq(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Sample outputs settled from the previous rising edge, then drive ws for the next one.
   task automatic tick(input logic new_ws);
      @(negedge sclk);
      if (fs_o) fs_cnt++;
      if (pu_o) pu_cnt++;
      if (!rst_i2s_n) low_cnt++;
      ws = new_ws;
   endtask

   task automatic frame(input int len, input int chg_at, input logic [3:0] nf,
                        input logic [3:0] ns);
      for (int i = 0; i < len; i++) begin
         tick(i >= len / 2);
         if (i == chg_at) begin
            freq_r  = nf;
            scale_r = ns;
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst_n   = 1'b1;
      ws      = 1'b1;
      freq_r  = 4'h1;
      scale_r = 4'h1;
      fs_cnt  = 0;
      pu_cnt  = 0;
      low_cnt = 0;
      #2 rst_n = 1'b0;
      repeat (3) @(negedge sclk);
      check_eq("rst_freq", freq_o, 1);
      check_eq("rst_scale", scale_o, 1);
      check_eq("rst_pu", pu_o, 0);
      check_eq("rst_fs", fs_o, 0);
      check_eq("rst_err", err_led, 0);
      check_eq("rst_i2s", rst_i2s_n, 0);

      @(negedge sclk);
      rst_n = 1'b1;
      @(posedge sclk);
      #1 check_eq("i2s_release", rst_i2s_n, 1);

      // Valid frames: the first start moves SYNC to RUN, every start pulses.
      pu_cnt = 0;
      for (int k = 0; k < 5; k++) begin
         fs_cnt = 0;
         frame(32, -1, 4'h1, 4'h1);
         check_eq($sformatf("fs_valid%0d", k), fs_cnt, 1);
      end
      check_eq("pu_none", pu_cnt, 0);

      // Frequency change mid-frame.
      frame(32, 10, 4'h4, 4'h1);
      for (int k = 1; k <= 5; k++) begin
         pu_cnt = 0;
         frame(32, -1, 4'h4, 4'h1);
         check_eq($sformatf("freq_pu%0d", k), pu_cnt, (k == Target) ? 1 : 0);
         check_eq($sformatf("freq_val%0d", k), freq_o, (k >= Target) ? 4 : 1);
      end

      // Scale change mid-frame.
      pu_cnt = 0;
      frame(32, 10, 4'h4, 4'h9);
      for (int k = 1; k <= 5; k++) frame(32, -1, 4'h4, 4'h9);
      check_eq("scale_pu", pu_cnt, 1);
      check_eq("scale_val", scale_o, 9);
      check_eq("scale_freq", freq_o, 4);

      // Watchdog: ws held low in RUN.
      low_cnt   = 0;
      first_low = -1;
      for (int i = 0; i < 110; i++) begin
         tick(1'b0);
         if (first_low < 0 && low_cnt > 0) first_low = i;
      end
      check_eq("wdog_latency", int'(first_low >= 62 && first_low <= 68), 1);
      check_eq("wdog_err", err_led, 1);
      check_eq("wdog_low_len", low_cnt, 8);
      check_eq("wdog_i2s_back", rst_i2s_n, 1);

      // Back to RUN, settings held across fault.
      for (int k = 0; k < 3; k++) frame(32, -1, 4'h4, 4'h9);
      check_eq("hold_freq", freq_o, 4);
      check_eq("hold_scale", scale_o, 9);

      // Short frame with a coinciding setting change.
      fs_cnt = 0;
      frame(30, 10, 4'h7, 4'h9);
      check_eq("short_start_ok", fs_cnt, 1);
      fs_cnt  = 0;
      pu_cnt  = 0;
      low_cnt = 0;
      frame(32, 2, 4'h4, 4'h9);
      check_eq("short_fs", fs_cnt, 0);
      check_eq("short_pu", pu_cnt, 0);
      check_eq("short_freq", freq_o, 4);
      check_eq("short_low_len", low_cnt, 8);
      check_eq("short_err", err_led, 1);

      // Reset asserted in the middle of RECOVER.
      frame(32, -1, 4'h4, 4'h9);
      frame(32, -1, 4'h4, 4'h9);
      frame(30, -1, 4'h4, 4'h9);
      repeat (4) tick(1'b0);
      check_eq("rec_in_progress", rst_i2s_n, 0);
      #2 rst_n = 1'b0;
      #1;
      check_eq("arst_err", err_led, 0);
      check_eq("arst_i2s", rst_i2s_n, 0);
      check_eq("arst_freq", freq_o, 1);
      check_eq("arst_scale", scale_o, 1);
      check_eq("arst_fs", fs_o, 0);
      check_eq("arst_pu", pu_o, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
